// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared definitions for the instruction fetch controller: default bus
// widths, the opcodes the controller itself interprets, the two-byte
// decode rule and the controller state encoding.
package fetch_ctrl_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;

  // Opcodes that change control flow inside the fetch controller.
  // Every other opcode is passed through to the execute unit.
  localparam logic [3:0] OP_HLT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_ARG,
    S_ARG,
    S_ISSUE,
    S_HALT
  } state_t;

  // The top opcode bit selects the two-byte format {op, imm}, b2.
  function automatic logic is_two_byte(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/fetch_ctrl_decode.sv
// fetch_ctrl_decode
// Purely combinational opcode classifier used by fetch_ctrl.
// Ports:
//   op        in   4  opcode nibble under inspection
//   cond      in   1  branch condition for JC
//   two_byte  out  1  opcode carries a second byte
//   halt      out  1  opcode is HLT
//   branch    out  1  opcode is JMP or JC (never issued)
//   taken     out  1  branch redirects the PC (JMP, or JC with cond=1)
module fetch_ctrl_decode
  import fetch_ctrl_pkg::*;
(
  input  logic [3:0] op,
  input  logic       cond,
  output logic       two_byte,
  output logic       halt,
  output logic       branch,
  output logic       taken
);

  // Classification is stateless; the controller decides when it matters.
  always_comb begin
    two_byte = is_two_byte(op);
    halt     = (op == OP_HLT);
    branch   = (op == OP_JMP) || (op == OP_JC);
    taken    = (op == OP_JMP) || ((op == OP_JC) && cond);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Instruction fetch/decode sequencer. Drives an external PC and fetch
// register, assembles one- and two-byte instructions, resolves JMP/JC
// locally and hands everything else to the execute unit over a
// valid/ready handshake.
// Ports:
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous reset, active low
//   start      in   1       leave IDLE and begin at boot_addr
//   stop       in   1       synchronous abort to IDLE, highest priority
//   boot_addr  in   ADDR_W  first instruction address
//   instr      in   DATA_W  fetch register contents
//   cond       in   1       JC branch condition
//   ir_ready   in   1       execute unit accepts the issued instruction
//   pc_en      out  1       PC increment enable
//   pc_load    out  1       PC parallel load
//   pc_d       out  ADDR_W  PC load value
//   fetch_en   out  1       fetch register capture enable
//   ir_valid   out  1       issued instruction valid
//   opcode     out  4       issued opcode
//   operand    out  ADDR_W  issued operand
//   halted     out  1       controller is in HALT
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [DATA_W-1:0] instr,
  input  logic              cond,
  input  logic              ir_ready,
  output logic              pc_en,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_d,
  output logic              fetch_en,
  output logic              ir_valid,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] operand,
  output logic              halted
);

  state_t            state_q, state_d;
  logic [3:0]        op_s, imm_s;
  logic [3:0]        opcode_q;
  logic [ADDR_W-1:0] operand_q;

  logic [3:0]        cur_op, cur_imm, dec_op;
  logic [ADDR_W-1:0] ext_val;
  logic              dec_two, dec_halt, dec_branch, dec_taken;
  logic              save_arg, latch_issue;
  logic [3:0]        latch_op;
  logic [ADDR_W-1:0] latch_opnd;

  assign cur_op  = instr[DATA_W-1 -: 4];
  assign cur_imm = instr[DATA_W-5 -: 4];
  assign ext_val = ADDR_W'({imm_s, instr});

  // In ARG the fetch register holds b2, so the saved first-byte opcode
  // is what must be classified.
  assign dec_op = (state_q == S_ARG) ? op_s : cur_op;

  fetch_ctrl_decode u_decode (
    .op       (dec_op),
    .cond     (cond),
    .two_byte (dec_two),
    .halt     (dec_halt),
    .branch   (dec_branch),
    .taken    (dec_taken)
  );

  // Next-state and PC/fetch control. Outputs are a function of the
  // current state plus inputs so that IDLE can load the PC in the same
  // cycle start is seen. stop (and a held reset) suppress every strobe.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    pc_d        = '0;
    fetch_en    = 1'b0;
    save_arg    = 1'b0;
    latch_issue = 1'b0;
    latch_op    = cur_op;
    latch_opnd  = ADDR_W'(cur_imm);
    if (!reset || stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_load = 1'b1;
            pc_d    = boot_addr;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          fetch_en = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
        S_DECODE: begin
          if (dec_halt) begin
            state_d = S_HALT;
          end else if (dec_two) begin
            save_arg = 1'b1;
            state_d  = S_FETCH_ARG;
          end else begin
            latch_issue = 1'b1;
            state_d     = S_ISSUE;
          end
        end
        S_FETCH_ARG: begin
          fetch_en = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_ARG;
        end
        S_ARG: begin
          if (dec_taken) begin
            pc_load = 1'b1;
            pc_d    = ext_val;
            state_d = S_FETCH;
          end else if (dec_branch) begin
            state_d = S_FETCH;
          end else begin
            latch_issue = 1'b1;
            latch_op    = op_s;
            latch_opnd  = ext_val;
            state_d     = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ir_ready) begin
            state_d = S_FETCH;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, saved first byte and the issue register. The issue register
  // is only written on entry to ISSUE, which keeps it stable while the
  // execute unit stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_s      <= '0;
      imm_s     <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
    end else begin
      state_q <= state_d;
      if (save_arg) begin
        op_s  <= cur_op;
        imm_s <= cur_imm;
      end
      if (latch_issue) begin
        opcode_q  <= latch_op;
        operand_q <= latch_opnd;
      end
    end
  end

  // Issue fields are only presented while valid, so IDLE and HALT show
  // all-zero outputs regardless of what was last issued.
  assign ir_valid = (state_q == S_ISSUE);
  assign opcode   = (state_q == S_ISSUE) ? opcode_q : 4'h0;
  assign operand  = (state_q == S_ISSUE) ? operand_q : '0;
  assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl: a table of single-cycle vectors
// with the fetch register driven directly, followed by sequences that
// run against a small PC/ROM/fetch-register environment.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, cond, ir_ready;
  logic [11:0] boot_addr;
  logic [7:0]  instr;
  logic        pc_en, pc_load, fetch_en, ir_valid, halted;
  logic [11:0] pc_d, operand;
  logic [3:0]  opcode;

  logic        use_env;
  logic [7:0]  instr_drv;
  logic [11:0] env_pc = 12'h000;
  logic [7:0]  env_freg = 8'h00;
  logic [7:0]  rom [0:4095];

  int checks_done = 0;
  int fail_count  = 0;

  typedef struct {
    string       name;
    logic        start;
    logic        stop;
    logic        cond;
    logic        rdy;
    logic [7:0]  instr;
    logic [11:0] boot;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs[32];

  always #5 clk = ~clk;

  assign instr = use_env ? env_freg : instr_drv;

  // External PC and fetch register as they sit next to the controller.
  always @(posedge clk) begin
    if (pc_load)
      env_pc <= pc_d;
    else if (pc_en)
      env_pc <= env_pc + 12'd1;
    if (fetch_en)
      env_freg <= rom[env_pc];
  end

  fetch_ctrl #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .boot_addr (boot_addr),
    .instr     (instr),
    .cond      (cond),
    .ir_ready  (ir_ready),
    .pc_en     (pc_en),
    .pc_load   (pc_load),
    .pc_d      (pc_d),
    .fetch_en  (fetch_en),
    .ir_valid  (ir_valid),
    .opcode    (opcode),
    .operand   (operand),
    .halted    (halted)
  );

  function automatic logic [32:0] mk(input logic pe, input logic pl, input logic [11:0] pd,
                                     input logic fe, input logic v, input logic [3:0] op,
                                     input logic [11:0] opnd, input logic h);
    return {pe, pl, pd, fe, v, op, opnd, h};
  endfunction

  function automatic vec_t mkvec(input string n, input logic s, input logic sp, input logic c,
                                 input logic r, input logic [7:0] i, input logic [11:0] b,
                                 input logic [32:0] e);
    vec_t t;
    t.name = n; t.start = s; t.stop = sp; t.cond = c; t.rdy = r;
    t.instr = i; t.boot = b; t.exp = e;
    return t;
  endfunction

  function automatic logic [32:0] outs();
    return {pc_en, pc_load, pc_d, fetch_en, ir_valid, opcode, operand, halted};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_done++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start     = v.start;
    stop      = v.stop;
    cond      = v.cond;
    ir_ready  = v.rdy;
    instr_drv = v.instr;
    boot_addr = v.boot;
  endtask

  task automatic doReset();
    reset = 1'b0; start = 1'b0; stop = 1'b0; cond = 1'b0; ir_ready = 1'b1;
    boot_addr = 12'h000; instr_drv = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // sel: 0 = ir_valid, 1 = pc_load, 2 = halted
  task automatic waitFor(input string name, input int sel, input int budget);
    logic found;
    found = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if ((sel == 0 && ir_valid) || (sel == 1 && pc_load) || (sel == 2 && halted)) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput(name, {63'd0, found}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = 8'h00;
    use_env = 1'b0;

    //                 name          st sp c  r  instr  boot        pe pl pd     fe v  op    opnd    h
    vecs[0]  = mkvec("idle",        0, 0, 0, 1, 8'h00, 12'h010, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));
    vecs[1]  = mkvec("start",       1, 0, 0, 1, 8'h00, 12'h010, mk(0, 1, 12'h010, 0, 0, 4'h0, 12'h000, 0));
    vecs[2]  = mkvec("fetch_a",     0, 0, 0, 1, 8'h00, 12'h010, mk(1, 0, 12'h000, 1, 0, 4'h0, 12'h000, 0));
    vecs[3]  = mkvec("dec_23",      0, 0, 0, 1, 8'h23, 12'h010, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));
    vecs[4]  = mkvec("issue_wait",  0, 0, 0, 0, 8'h23, 12'h010, mk(0, 0, 12'h000, 0, 1, 4'h2, 12'h003, 0));
    vecs[5]  = mkvec("issue_acc",   0, 0, 0, 1, 8'h23, 12'h010, mk(0, 0, 12'h000, 0, 1, 4'h2, 12'h003, 0));
    vecs[6]  = mkvec("fetch_b",     0, 0, 0, 1, 8'h00, 12'h010, mk(1, 0, 12'h000, 1, 0, 4'h0, 12'h000, 0));
    vecs[7]  = mkvec("dec_84",      0, 0, 0, 1, 8'h84, 12'h010, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));
    vecs[8]  = mkvec("farg_84",     0, 0, 0, 1, 8'h84, 12'h010, mk(1, 0, 12'h000, 1, 0, 4'h0, 12'h000, 0));
    vecs[9]  = mkvec("arg_jmp",     0, 0, 0, 1, 8'h56, 12'h010, mk(0, 1, 12'h456, 0, 0, 4'h0, 12'h000, 0));
    vecs[10] = mkvec("fetch_c",     0, 0, 0, 1, 8'h00, 12'h010, mk(1, 0, 12'h000, 1, 0, 4'h0, 12'h000, 0));
    vecs[11] = mkvec("dec_91",      0, 0, 0, 1, 8'h91, 12'h010, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));
    vecs[12] = mkvec("farg_91",     0, 0, 0, 1, 8'h91, 12'h010, mk(1, 0, 12'h000, 1, 0, 4'h0, 12'h000, 0));
    vecs[13] = mkvec("arg_jc_nt",   0, 0, 0, 1, 8'h00, 12'h010, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));
    vecs[14] = mkvec("fetch_d",     0, 0, 0, 1, 8'h00, 12'h010, mk(1, 0, 12'h000, 1, 0, 4'h0, 12'h000, 0));
    vecs[15] = mkvec("dec_91b",     0, 0, 0, 1, 8'h91, 12'h010, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));
    vecs[16] = mkvec("farg_91b",    0, 0, 0, 1, 8'h91, 12'h010, mk(1, 0, 12'h000, 1, 0, 4'h0, 12'h000, 0));
    vecs[17] = mkvec("arg_jc_t",    0, 0, 1, 1, 8'h00, 12'h010, mk(0, 1, 12'h100, 0, 0, 4'h0, 12'h000, 0));
    vecs[18] = mkvec("fetch_e",     0, 0, 0, 1, 8'h00, 12'h010, mk(1, 0, 12'h000, 1, 0, 4'h0, 12'h000, 0));
    vecs[19] = mkvec("dec_a3",      0, 0, 0, 1, 8'hA3, 12'h010, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));
    vecs[20] = mkvec("farg_a3",     0, 0, 0, 1, 8'hA3, 12'h010, mk(1, 0, 12'h000, 1, 0, 4'h0, 12'h000, 0));
    vecs[21] = mkvec("arg_a3",      0, 0, 0, 1, 8'hBC, 12'h010, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));
    vecs[22] = mkvec("issue_a3",    0, 0, 0, 1, 8'hBC, 12'h010, mk(0, 0, 12'h000, 0, 1, 4'hA, 12'h3BC, 0));
    vecs[23] = mkvec("fetch_stop",  0, 1, 0, 1, 8'h00, 12'h010, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));
    vecs[24] = mkvec("start_stop",  1, 1, 0, 1, 8'h00, 12'h010, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));
    vecs[25] = mkvec("start_fff",   1, 0, 0, 1, 8'h00, 12'hFFF, mk(0, 1, 12'hFFF, 0, 0, 4'h0, 12'h000, 0));
    vecs[26] = mkvec("fetch_f",     0, 0, 0, 1, 8'h00, 12'hFFF, mk(1, 0, 12'h000, 1, 0, 4'h0, 12'h000, 0));
    vecs[27] = mkvec("dec_70",      0, 0, 0, 1, 8'h70, 12'hFFF, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));
    vecs[28] = mkvec("halt_a",      1, 0, 0, 1, 8'h00, 12'hFFF, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 1));
    vecs[29] = mkvec("halt_b",      0, 0, 0, 1, 8'h00, 12'hFFF, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 1));
    vecs[30] = mkvec("halt_stop",   0, 1, 0, 1, 8'h00, 12'hFFF, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 1));
    vecs[31] = mkvec("idle_end",    0, 0, 0, 1, 8'h00, 12'hFFF, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0));

    // Reset state, including a start request while reset is held.
    doReset();
    reset = 1'b0;
    start = 1'b1;
    boot_addr = 12'h010;
    #1;
    checkOutput("reset_outputs", {31'd0, outs()}, {31'd0, 33'd0});
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i].name, {31'd0, outs()}, {31'd0, vecs[i].exp});
    end

    // Boot, one-byte issue, JMP to 0x456 and HALT against the PC/ROM model.
    doReset();
    use_env = 1'b1;
    rom[12'h010] = 8'h23;
    rom[12'h011] = 8'h84;
    rom[12'h012] = 8'h56;
    rom[12'h456] = 8'h70;
    @(negedge clk);
    start = 1'b1; boot_addr = 12'h010; ir_ready = 1'b1;
    #1;
    checkOutput("boot_load", {50'd0, pc_load, pc_en, pc_d}, {50'd0, 1'b1, 1'b0, 12'h010});
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("boot_fetch", {49'd0, fetch_en, pc_en, env_pc}, {49'd0, 1'b1, 1'b1, 12'h010});
    @(negedge clk);
    @(negedge clk); #1;
    checkOutput("issue_23", {47'd0, ir_valid, opcode, operand}, {47'd0, 1'b1, 4'h2, 12'h003});
    waitFor("jmp_load_seen", 1, 10);
    checkOutput("jmp_target", {52'd0, pc_d}, {52'd0, 12'h456});
    @(negedge clk); #1;
    checkOutput("fetch_at_456", {51'd0, fetch_en, env_pc}, {51'd0, 1'b1, 12'h456});
    waitFor("halt_seen", 2, 10);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checkOutput("halt_sticky", {31'd0, outs()}, {31'd0, mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 1)});
    end
    start = 1'b0;
    stop  = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    #1;
    checkOutput("halt_exit", {31'd0, outs()}, {31'd0, 33'd0});

    // Execute unit stalls for five cycles; the issue must hold still.
    doReset();
    rom[12'h100] = 8'hA3;
    rom[12'h101] = 8'hBC;
    @(negedge clk);
    start = 1'b1; boot_addr = 12'h100; ir_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    waitFor("stall_valid_seen", 0, 10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checkOutput("stall_hold", {45'd0, ir_valid, opcode, operand, fetch_en, pc_en},
                  {45'd0, 1'b1, 4'hA, 12'h3BC, 1'b0, 1'b0});
    end

    // Asynchronous reset in the middle of ISSUE, then remain idle.
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("reset_mid_issue", {31'd0, outs()}, {31'd0, 33'd0});
    @(negedge clk);
    reset = 1'b1; start = 1'b0; ir_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checkOutput("idle_after_reset", {31'd0, outs()}, {31'd0, 33'd0});
    end

    // Two-byte op at 0xFFF takes its second byte from 0x000.
    rom[12'hFFF] = 8'hA1;
    rom[12'h000] = 8'h22;
    @(negedge clk);
    start = 1'b1; boot_addr = 12'hFFF;
    @(negedge clk);
    start = 1'b0;
    waitFor("wrap_valid_seen", 0, 10);
    checkOutput("wrap_issue", {47'd0, ir_valid, opcode, operand}, {47'd0, 1'b1, 4'hA, 12'h122});

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
    $finish;
  end

endmodule
